// File: rtl/mem_response_stage.sv
// Memory response stage between EX and WB.
// Holds one instruction. A load waits here for its in-order data_ok response,
// and the load data is aligned and extended before it is handed to WB.
// Responses that belong to flushed loads are counted and dropped, so stale
// data never reaches WB.
module mem_response_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MAX_OUTSTANDING = 2,
    localparam int NB             = DATA_WIDTH / 8,
    localparam int OFF_W          = $clog2(NB)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_WIDTH-1:0]       in_pc,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest,
    input  logic                      in_reg_write,
    input  logic                      in_is_load,
    input  logic [2:0]                in_load_kind,
    input  logic                      in_unsigned,
    input  logic [OFF_W-1:0]          in_addr_low,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic                      flush,
    input  logic                      data_ok,
    input  logic [DATA_WIDTH-1:0]     data_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [REG_ADDR_WIDTH-1:0] out_dest,
    output logic [NB-1:0]             out_wstrb,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      fwd_valid,
    output logic                      fwd_data_ok
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [2:0] LK_BYTE  = 3'd0;
    localparam logic [2:0] LK_HALF  = 3'd1;
    localparam logic [2:0] LK_WORD  = 3'd2;
    localparam logic [2:0] LK_LEFT  = 3'd4;
    localparam logic [2:0] LK_RIGHT = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_DONE      = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          discard_cnt_q, discard_cnt_d;
    logic                      resp_buf_valid_q, resp_buf_valid_d;
    logic [DATA_WIDTH-1:0]     resp_buf_q, resp_buf_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                      reg_write_q, reg_write_d;
    logic [2:0]                kind_q, kind_d;
    logic                      unsigned_q, unsigned_d;
    logic [OFF_W-1:0]          addr_low_q, addr_low_d;
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;

    logic             stage_valid;
    logic             fire_out;
    logic             accept;
    logic             kill_wait;
    logic             drop_resp;
    logic             capture;
    logic [CNT_W:0]   cnt_sum;
    logic             cnt_overflow;

    // Select the addressed lane and extend it; left/right merge shifts.
    function automatic logic [DATA_WIDTH-1:0] align_load(
        input logic [2:0]            kind,
        input logic                  is_unsigned,
        input logic [OFF_W-1:0]      k,
        input logic [DATA_WIDTH-1:0] rdata
    );
        logic [DATA_WIDTH-1:0]        lane;
        logic signed [7:0]            lane_b;
        logic signed [15:0]           lane_h;
        logic signed [31:0]           lane_w;
        logic signed [DATA_WIDTH-1:0] ext;
        int unsigned                  sh_lane;
        int unsigned                  sh_left;
        sh_lane = 32'(k) * 8;
        sh_left = (32'(NB - 1) - 32'(k)) * 8;
        lane    = rdata >> sh_lane;
        lane_b  = signed'(lane[7:0]);
        lane_h  = signed'(lane[15:0]);
        lane_w  = signed'(lane[31:0]);
        case (kind)
            LK_BYTE: begin
                ext = lane_b;
                if (is_unsigned) align_load = DATA_WIDTH'(lane[7:0]);
                else             align_load = ext;
            end
            LK_HALF: begin
                ext = lane_h;
                if (is_unsigned) align_load = DATA_WIDTH'(lane[15:0]);
                else             align_load = ext;
            end
            LK_WORD: begin
                ext = lane_w;
                if (is_unsigned) align_load = DATA_WIDTH'(lane[31:0]);
                else             align_load = ext;
            end
            LK_LEFT:  align_load = rdata << sh_left;
            LK_RIGHT: align_load = rdata >> sh_lane;
            default:  align_load = rdata;
        endcase
    endfunction

    // Register byte-write strobe; only the partial merges write a subset.
    function automatic logic [NB-1:0] load_strobe(
        input logic [2:0]       kind,
        input logic [OFF_W-1:0] k
    );
        logic [NB-1:0] ones;
        ones = '1;
        case (kind)
            LK_LEFT:  load_strobe = ones << (32'(NB - 1) - 32'(k));
            LK_RIGHT: load_strobe = ones >> k;
            default:  load_strobe = ones;
        endcase
    endfunction

    assign stage_valid = (state_q != ST_EMPTY);
    assign out_valid   = (state_q == ST_DONE);
    assign fire_out    = out_valid & out_ready;
    assign in_ready    = ~stage_valid | fire_out;
    assign accept      = in_valid & in_ready & ~flush;
    // A flushed load still owes a response; it must be swallowed later.
    assign kill_wait   = flush & (state_q == ST_WAIT_DATA);
    // With a simultaneous flush the arriving response is the killed load's own.
    assign drop_resp   = data_ok & ((discard_cnt_q != '0) | kill_wait);
    assign capture     = data_ok & (discard_cnt_q == '0) & (state_q == ST_WAIT_DATA) & ~flush;

    assign out_pc      = pc_q;
    assign out_dest    = dest_q;
    assign out_result  = resp_buf_valid_q ? align_load(kind_q, unsigned_q, addr_low_q, resp_buf_q)
                                          : alu_q;
    assign out_wstrb   = !out_valid       ? '0
                       : resp_buf_valid_q ? load_strobe(kind_q, addr_low_q)
                                          : '1;
    assign fwd_valid   = stage_valid & reg_write_q;
    assign fwd_data_ok = (state_q == ST_DONE);

    // Stage state: capture, hand-off and acceptance, with flush taking priority.
    always_comb begin
        state_d          = state_q;
        resp_buf_valid_d = resp_buf_valid_q;
        if (capture) begin
            state_d          = ST_DONE;
            resp_buf_valid_d = 1'b1;
        end
        if (fire_out) begin
            state_d = ST_EMPTY;
        end
        if (accept) begin
            state_d          = in_is_load ? ST_WAIT_DATA : ST_DONE;
            resp_buf_valid_d = 1'b0;
        end
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Count of responses still owed to flushed loads, saturating at the limit.
    always_comb begin
        cnt_sum       = {1'b0, discard_cnt_q} + (CNT_W + 1)'(kill_wait) - (CNT_W + 1)'(drop_resp);
        cnt_overflow  = (cnt_sum > (CNT_W + 1)'(MAX_OUTSTANDING));
        discard_cnt_d = cnt_overflow ? CNT_W'(MAX_OUTSTANDING) : cnt_sum[CNT_W-1:0];
    end

    // Instruction fields latch on acceptance; response data on capture.
    always_comb begin
        pc_d        = pc_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        kind_d      = kind_q;
        unsigned_d  = unsigned_q;
        addr_low_d  = addr_low_q;
        alu_d       = alu_q;
        resp_buf_d  = capture ? data_rdata : resp_buf_q;
        if (accept) begin
            pc_d        = in_pc;
            dest_d      = in_dest;
            reg_write_d = in_reg_write;
            kind_d      = in_load_kind;
            unsigned_d  = in_unsigned;
            addr_low_d  = in_addr_low;
            alu_d       = in_alu_result;
        end
    end

    // Control registers; these are the only ones that need a reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_EMPTY;
            discard_cnt_q    <= '0;
            resp_buf_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            discard_cnt_q    <= discard_cnt_d;
            resp_buf_valid_q <= resp_buf_valid_d;
        end
    end

    // Payload registers; qualified by the control state, so left unreset.
    always_ff @(posedge clock) begin
        pc_q        <= pc_d;
        dest_q      <= dest_d;
        reg_write_q <= reg_write_d;
        kind_q      <= kind_d;
        unsigned_q  <= unsigned_d;
        addr_low_q  <= addr_low_d;
        alu_q       <= alu_d;
        resp_buf_q  <= resp_buf_d;
    end

    // More flushed loads in flight than the counter can hold.
    discard_overflow_a: assert property (@(posedge clock) disable iff (reset) !cnt_overflow);

endmodule

// File: tb/tb_mem_response_stage.sv
// Bench for mem_response_stage: a 32-bit instance checked every cycle against a
// transaction-level model (held instruction plus a queue of owed responses),
// and a 64-bit instance exercised with directed loads.
module tb_mem_response_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        in_valid, in_ready, in_reg_write, in_is_load, in_unsigned;
    logic [31:0] in_pc, in_alu_result, data_rdata, out_pc, out_result;
    logic [4:0]  in_dest, out_dest;
    logic [2:0]  in_load_kind;
    logic [1:0]  in_addr_low;
    logic        flush, data_ok, out_valid, out_ready, fwd_valid, fwd_data_ok;
    logic [3:0]  out_wstrb;

    logic        in_valid_w, in_ready_w, in_reg_write_w, in_is_load_w, in_unsigned_w;
    logic [31:0] in_pc_w, out_pc_w;
    logic [63:0] in_alu_result_w, data_rdata_w, out_result_w;
    logic [4:0]  in_dest_w, out_dest_w;
    logic [2:0]  in_load_kind_w, in_addr_low_w;
    logic        flush_w, data_ok_w, out_valid_w, out_ready_w, fwd_valid_w, fwd_data_ok_w;
    logic [7:0]  out_wstrb_w;

    int checks   = 0;
    int failures = 0;
    int xfer_cnt = 0;

    mem_response_stage #(.DATA_WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dest(in_dest),
        .in_reg_write(in_reg_write), .in_is_load(in_is_load), .in_load_kind(in_load_kind),
        .in_unsigned(in_unsigned), .in_addr_low(in_addr_low), .in_alu_result(in_alu_result),
        .flush(flush), .data_ok(data_ok), .data_rdata(data_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dest(out_dest),
        .out_wstrb(out_wstrb), .out_result(out_result),
        .fwd_valid(fwd_valid), .fwd_data_ok(fwd_data_ok)
    );

    mem_response_stage #(.DATA_WIDTH(64)) u_dut64 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_pc(in_pc_w), .in_dest(in_dest_w),
        .in_reg_write(in_reg_write_w), .in_is_load(in_is_load_w), .in_load_kind(in_load_kind_w),
        .in_unsigned(in_unsigned_w), .in_addr_low(in_addr_low_w), .in_alu_result(in_alu_result_w),
        .flush(flush_w), .data_ok(data_ok_w), .data_rdata(data_rdata_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_pc(out_pc_w), .out_dest(out_dest_w),
        .out_wstrb(out_wstrb_w), .out_result(out_result_w),
        .fwd_valid(fwd_valid_w), .fwd_data_ok(fwd_data_ok_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Byte-lane view of the load rules: result bytes and strobe per byte.
    function automatic void model_align(input int nb, input int kind, input bit uns, input int k,
                                        input logic [63:0] rd,
                                        output logic [63:0] res, output logic [7:0] strb);
        logic [7:0] b [8];
        logic [7:0] o [8];
        logic [7:0] fill;
        int n;
        for (int i = 0; i < 8; i++) begin
            b[i] = rd[8*i +: 8];
            o[i] = 8'h00;
        end
        strb = 8'h00;
        for (int i = 0; i < nb; i++) strb[i] = 1'b1;
        case (kind)
            0, 1, 2: begin
                n    = (kind == 0) ? 1 : (kind == 1) ? 2 : 4;
                fill = (!uns && b[k+n-1][7]) ? 8'hFF : 8'h00;
                for (int i = 0; i < nb; i++) o[i] = (i < n) ? b[k+i] : fill;
            end
            4: for (int i = 0; i < nb; i++) begin
                if (i >= nb - 1 - k) o[i] = b[i-(nb-1-k)];
                else strb[i] = 1'b0;
            end
            5: for (int i = 0; i < nb; i++) begin
                if (i + k < nb) o[i] = b[i+k];
                else strb[i] = 1'b0;
            end
            default: for (int i = 0; i < nb; i++) o[i] = b[i];
        endcase
        res = 64'h0;
        for (int i = 0; i < nb; i++) res[8*i +: 8] = o[i];
    endfunction

    // Model state for the 32-bit instance.
    bit          m_held = 0, m_has_data = 0, m_is_load = 0, m_reg_write = 0, m_uns = 0;
    int          m_kind = 0, m_k = 0;
    logic [31:0] m_pc, m_alu, m_rdata;
    logic [4:0]  m_dest;
    bit          pend_q[$];   // owed responses in issue order; 1 = live, 0 = flushed

    initial begin
        bit fire, rdy, alive;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_held = 0; m_has_data = 0;
                pend_q.delete();
            end else begin
                fire = m_held && m_has_data && out_ready;
                rdy  = !m_held || fire;
                if (flush && m_held && !m_has_data && pend_q.size() > 0)
                    pend_q[pend_q.size()-1] = 1'b0;
                if (data_ok) begin
                    checks++;
                    if (pend_q.size() == 0) begin
                        failures++;
                        $display("FAIL stray_response actual=data_ok required=no_response");
                    end else begin
                        alive = pend_q.pop_front();
                        if (alive) begin
                            m_has_data = 1;
                            m_rdata    = data_rdata;
                        end
                    end
                end
                if (flush) begin
                    m_held = 0;
                end else begin
                    if (fire) m_held = 0;
                    if (in_valid && rdy) begin
                        m_held = 1; m_has_data = !in_is_load; m_is_load = in_is_load;
                        m_reg_write = in_reg_write; m_pc = in_pc; m_dest = in_dest;
                        m_kind = int'(in_load_kind); m_uns = in_unsigned; m_k = int'(in_addr_low);
                        m_alu = in_alu_result;
                        if (in_is_load) pend_q.push_back(1'b1);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] er;
        logic [7:0]  es;
        bit          ov;
        int          nkill;
        forever begin
            @(negedge clock);
            if (!reset) begin
                ov = m_held && m_has_data;
                chk("out_valid", out_valid, ov);
                chk("in_ready", in_ready, !m_held || (ov && out_ready));
                chk("fwd_valid", fwd_valid, m_held && m_reg_write);
                chk("fwd_data_ok", fwd_data_ok, ov);
                if (ov) begin
                    if (m_is_load) model_align(4, m_kind, m_uns, m_k, {32'h0, m_rdata}, er, es);
                    else begin er = {32'h0, m_alu}; es = 8'h0F; end
                    chk("out_result", out_result, er);
                    chk("out_wstrb", out_wstrb, es);
                    chk("out_pc", out_pc, m_pc);
                    chk("out_dest", out_dest, m_dest);
                    if (out_ready) xfer_cnt++;
                end else begin
                    chk("out_wstrb_idle", out_wstrb, 0);
                end
                nkill = 0;
                foreach (pend_q[i]) if (!pend_q[i]) nkill++;
                chk("discard_cnt", u_dut32.discard_cnt_q, nkill);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input bit is_load, input logic [2:0] kind, input bit uns,
                        input logic [1:0] k, input logic [31:0] alu, input logic [31:0] pc);
        bit got = 0;
        in_valid = 1; in_is_load = is_load; in_load_kind = kind; in_unsigned = uns;
        in_addr_low = k; in_alu_result = alu; in_pc = pc; in_dest = pc[4:0]; in_reg_write = 1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            got = in_ready && !flush;
            tick();
        end
        in_valid = 0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted pc=%0h", pc);
        end
    endtask

    task automatic respond(input logic [31:0] d);
        data_ok = 1; data_rdata = d;
        tick();
        data_ok = 0;
    endtask

    task automatic expect_out(input logic [31:0] r, input logic [3:0] s, input string name);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock);
            if (out_valid) begin
                seen = 1;
                chk({name, "_result"}, out_result, r);
                chk({name, "_wstrb"}, out_wstrb, s);
            end
            tick();
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
        end
    endtask

    task automatic run64(input logic [2:0] kind, input bit uns, input logic [2:0] k,
                         input logic [63:0] rd, input logic [63:0] exp_r, input logic [7:0] exp_s,
                         input string name);
        logic [63:0] mr;
        logic [7:0]  ms;
        in_valid_w = 1; in_is_load_w = 1; in_load_kind_w = kind; in_unsigned_w = uns;
        in_addr_low_w = k; in_pc_w = 32'h0000_4000 + 32'(k); in_dest_w = 5'd9; in_reg_write_w = 1;
        @(negedge clock);
        chk({name, "_in_ready"}, in_ready_w, 1);
        tick();
        in_valid_w = 0; data_ok_w = 1; data_rdata_w = rd;
        tick();
        data_ok_w = 0;
        @(negedge clock);
        model_align(8, int'(kind), uns, int'(k), rd, mr, ms);
        chk({name, "_valid"}, out_valid_w, 1);
        chk({name, "_result"}, out_result_w, exp_r);
        chk({name, "_wstrb"}, out_wstrb_w, exp_s);
        chk({name, "_model_result"}, out_result_w, mr);
        chk({name, "_model_wstrb"}, out_wstrb_w, ms);
        chk({name, "_pc"}, out_pc_w, 32'h0000_4000 + 32'(k));
        chk({name, "_dest"}, out_dest_w, 5'd9);
        chk({name, "_fwd"}, {fwd_valid_w, fwd_data_ok_w}, 2'b11);
        tick();
        @(negedge clock);
        chk({name, "_drained"}, out_valid_w, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int x0;
        reset = 1;
        in_valid = 0; in_pc = 0; in_dest = 0; in_reg_write = 0; in_is_load = 0; in_load_kind = 0;
        in_unsigned = 0; in_addr_low = 0; in_alu_result = 0; flush = 0; data_ok = 0;
        data_rdata = 0; out_ready = 1;
        in_valid_w = 0; in_pc_w = 0; in_dest_w = 0; in_reg_write_w = 0; in_is_load_w = 0;
        in_load_kind_w = 0; in_unsigned_w = 0; in_addr_low_w = 0; in_alu_result_w = 0;
        flush_w = 0; data_ok_w = 0; data_rdata_w = 0; out_ready_w = 1;
        repeat (3) @(posedge clock);
        #1 reset = 0;

        @(negedge clock);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_wstrb", out_wstrb, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_fwd_valid", fwd_valid, 0);
        chk("reset_discard", u_dut32.discard_cnt_q, 0);
        chk("reset_out_valid_64", out_valid_w, 0);
        chk("reset_out_wstrb_64", out_wstrb_w, 0);
        tick();

        send(1, 3'd0, 0, 2'd3, 32'h0, 32'h100);
        respond(32'h80AA_BB11);
        expect_out(32'hFFFF_FF80, 4'hF, "lb_signed");
        send(1, 3'd0, 1, 2'd3, 32'h0, 32'h104);
        respond(32'h80AA_BB11);
        expect_out(32'h0000_0080, 4'hF, "lbu");
        send(1, 3'd4, 0, 2'd1, 32'h0, 32'h108);
        respond(32'h1122_3344);
        expect_out(32'h3344_0000, 4'b1100, "lwl");
        send(1, 3'd5, 0, 2'd1, 32'h0, 32'h10C);
        respond(32'h1122_3344);
        expect_out(32'h0011_2233, 4'b0111, "lwr");
        send(1, 3'd1, 0, 2'd2, 32'h0, 32'h110);
        respond(32'h9ABC_0000);
        expect_out(32'hFFFF_9ABC, 4'hF, "lh");
        send(0, 3'd0, 0, 2'd0, 32'h1234_5678, 32'h114);
        expect_out(32'h1234_5678, 4'hF, "alu");

        // Slow memory and a stalled WB: result must hold until the single hand-off.
        out_ready = 0;
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h200);
        repeat (4) begin
            @(negedge clock);
            chk("wait_in_ready", in_ready, 0);
            chk("wait_fwd", {fwd_valid, fwd_data_ok}, 2'b10);
            tick();
        end
        respond(32'hCAFE_F00D);
        x0 = xfer_cnt;
        repeat (3) begin
            @(negedge clock);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, 32'hCAFE_F00D);
            chk("hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1;
        tick();
        tick();
        chk("one_transfer", xfer_cnt - x0, 1);

        // Flushed load's response must be dropped; the next load gets its own.
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h300);
        flush = 1;
        tick();
        flush = 0;
        @(negedge clock);
        chk("discard_after_flush", u_dut32.discard_cnt_q, 1);
        tick();
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h304);
        respond(32'h0000_DEAD);
        respond(32'h0000_BEEF);
        expect_out(32'h0000_BEEF, 4'hF, "after_flush");
        @(negedge clock);
        chk("discard_back_to_zero", u_dut32.discard_cnt_q, 0);
        tick();

        // Flush and response in the same cycle cancel out.
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h400);
        flush = 1; data_ok = 1; data_rdata = 32'h1234_5678;
        tick();
        flush = 0; data_ok = 0;
        repeat (3) begin
            @(negedge clock);
            chk("simul_no_out", out_valid, 0);
            chk("simul_discard", u_dut32.discard_cnt_q, 0);
            tick();
        end

        // Two flushed loads in flight fill the discard counter to its limit.
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h500);
        flush = 1;
        tick();
        flush = 0;
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h504);
        flush = 1;
        tick();
        flush = 0;
        @(negedge clock);
        chk("discard_full", u_dut32.discard_cnt_q, 2);
        tick();
        respond(32'h1111_1111);
        respond(32'h2222_2222);
        @(negedge clock);
        chk("discard_drained", u_dut32.discard_cnt_q, 0);
        chk("discard_no_out", out_valid, 0);
        tick();

        // Back-to-back non-loads at full rate.
        x0 = xfer_cnt;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_is_load = 0; in_reg_write = 1;
            in_alu_result = 32'hA000_0000 + 32'(i); in_pc = 32'h600 + 32'(4 * i); in_dest = 5'(i + 1);
            @(negedge clock);
            chk("b2b_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 0;
        tick();
        chk("b2b_rate", xfer_cnt - x0, 4);

        // Reset while a load is outstanding clears everything.
        send(1, 3'd2, 0, 2'd0, 32'h0, 32'h700);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clock);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_fwd", fwd_valid, 0);
        chk("midreset_discard", u_dut32.discard_cnt_q, 0);
        chk("midreset_in_ready", in_ready, 1);
        tick();

        run64(3'd1, 0, 3'd6, 64'h8001_7777_6666_5555, 64'hFFFF_FFFF_FFFF_8001, 8'hFF, "ld_half64");
        run64(3'd2, 0, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 8'hFF, "ld_word64");
        run64(3'd0, 1, 3'd7, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0080, 8'hFF, "ld_byteu64");
        run64(3'd4, 0, 3'd2, 64'h1122_3344_5566_7788, 64'h6677_8800_0000_0000, 8'hE0, "ld_left64");
        run64(3'd5, 0, 3'd2, 64'h1122_3344_5566_7788, 64'h0000_1122_3344_5566, 8'h3F, "ld_right64");
        run64(3'd3, 0, 3'd0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 8'hFF, "ld_full64");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
